opbomp_pipeline_sequencer: RTL and testbench
============================================

Name: opbomp_pipeline_sequencer

Overview:
- Controls the registered stages of the OPBOMP decoder: input register, middle register, pseudoinverse RAM read and output register.
- Accepts frames on a valid/ready handshake and tracks each frame through PIPE_DEPTH stages with a valid/tag shift chain.
- Drives per-stage clock enables and the RAM enable.
- Presents decoded-frame valid and tag to the downstream consumer, with full backpressure.

Parameters:
- PIPE_DEPTH, 4, number of registered datapath stages from x capture to output_bits; legal range 2..8.
- RAM_STAGE, 2, index of the stage whose register is the pseudoinverse RAM output; legal range 1..PIPE_DEPTH-1.
- TAG_WIDTH, 8, width of the frame tag carried alongside each frame.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream frame x is valid.
- in_ready  out  1  sequencer can accept a frame this cycle.
- in_tag  in  TAG_WIDTH  tag of the upstream frame.
- flush  in  1  synchronous pipeline flush; discards all in-flight frames.
- stage_en  out  PIPE_DEPTH  clock enable for datapath stage register i.
- ram_en  out  1  read enable for the pseudoinverse RAM.
- out_valid  out  1  output_bits holds a decoded frame.
- out_ready  in  1  downstream accepts the decoded frame.
- out_tag  out  TAG_WIDTH  tag of the frame currently at the output.
- busy  out  1  at least one frame is in flight.
- frame_count  out  CNT_WIDTH  number of frames delivered.
- stall_count  out  CNT_WIDTH  number of cycles spent stalled by backpressure.

Behaviour:
- Internal state: valid bits v[0..PIPE_DEPTH-1] and tags t[0..PIPE_DEPTH-1].
- stall = v[PIPE_DEPTH-1] & ~out_ready.
- advance = ~stall & ~flush.
- in_ready = advance (combinational). A frame is accepted when in_valid & in_ready.
- On advance, at the clock edge:
  - v[0] <= in_valid and t[0] <= in_tag.
  - v[i] <= v[i-1] and t[i] <= t[i-1] for i >= 1.
  - Tags of bubbles are don't-care but must be deterministic; hold the previous value.
- On stall, v and t hold, so the output frame is stable until it is accepted.
- Stage enables are combinational:
  - stage_en[0] = advance & in_valid.
  - stage_en[i] = advance & v[i-1].
  - Bubbles do not toggle datapath registers.
- ram_en = stage_en[RAM_STAGE]. The RAM address (posmax) is valid in the cycle ram_en is high.
- out_valid = v[PIPE_DEPTH-1]; out_tag = t[PIPE_DEPTH-1].
- busy = OR of all v bits.
- Latency: a frame accepted in cycle n gives out_valid = 1 in cycle n + PIPE_DEPTH when there is no stall. Each stall cycle adds exactly one cycle.
- Throughput: one frame per cycle when out_ready is held high.
- A frame leaving the output and a new frame entering in the same cycle are both legal. The pipeline stays full with no bubble inserted.
- flush:
  - At the next edge, clears all v bits. Tags and counters are unchanged.
  - Has priority over acceptance: in_ready = 0 and all stage_en = 0 in the flush cycle.
  - An output handshake coinciding with flush is not counted and the frame is discarded.
- frame_count increments by 1 on out_valid & out_ready & ~flush, and wraps modulo 2^CNT_WIDTH.
- stall_count increments on every cycle with stall = 1 and flush = 0, and saturates at all-ones.
- Reset:
  - At the edge with reset = 1, all v = 0, all t = 0 and both counters = 0.
  - Reset has priority over flush and over handshakes.
  - During the reset cycle, stage_en = 0 and ram_en = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_tag = 0, busy = 0.
  - Reset asserted mid-stream drops every in-flight frame; no partial frame is ever presented.
- Behaviour of the out_valid/out_tag pair while stalled: values are held constant, and dropping out_valid without a handshake is forbidden (the bench asserts this).

Test Plan:
- Reset, then a single frame with tag 0x11 accepted in cycle 10, out_ready = 1 -> out_valid = 1 only in cycle 14 with out_tag = 0x11; frame_count = 1; busy is high in cycles 11..14.
- Eight back-to-back frames with tags 0x01..0x08, out_ready = 1 -> out_valid is continuous for 8 cycles starting 4 cycles after the first accept; tags arrive in order; frame_count = 8; stall_count = 0.
- Pipeline full, then out_ready = 0 for 3 cycles -> in_ready = 0 for those cycles, all stage_en = 0, out_tag held, stall_count = 3; on out_ready = 1, delivery resumes with no lost or duplicated tags.
- Frames with tags 0xA0 and 0xA2 separated by one idle cycle -> stage_en walks as a one-hot-per-frame diagonal with a bubble between; ram_en is high exactly in cycles n+2 and n+4 of the first accept, cycle n.
- Three frames in flight, flush = 1 for one cycle -> busy = 0 the next cycle, no out_valid for these frames, frame_count unchanged, in_ready = 0 during the flush cycle.
- Pipeline full and stalled, reset = 1 -> the next cycle shows out_valid = 0, busy = 0, frame_count = 0, stall_count = 0, in_ready = 1.

Source files
------------

// File: rtl/opbomp_pipeline_sequencer_if.sv
// Handshake, control and status bundle between the OPBOMP pipeline sequencer and its neighbours.
// The slave side is the sequencer; the master side is whoever drives frames and consumes results.
interface opbomp_pipeline_sequencer_if #(
  parameter int PIPE_DEPTH = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
);
  // valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
  // valid may not drop and its payload may not change until that transfer has happened.
  logic                  in_valid;
  logic                  in_ready;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  flush;
  logic [PIPE_DEPTH-1:0] stage_en;
  logic                  ram_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  frame_count;
  logic [CNT_WIDTH-1:0]  stall_count;

  modport master (
    output in_valid, in_tag, flush, out_ready,
    input  in_ready, stage_en, ram_en, out_valid, out_tag, busy, frame_count, stall_count
  );

  modport slave (
    input  in_valid, in_tag, flush, out_ready,
    output in_ready, stage_en, ram_en, out_valid, out_tag, busy, frame_count, stall_count
  );
endinterface

// File: rtl/opbomp_pipeline_sequencer.sv
// Valid/tag shift chain that sequences frames through the OPBOMP decoder stages and
// generates per-stage clock enables, the RAM read enable and delivery statistics.
module opbomp_pipeline_sequencer #(
  parameter int PIPE_DEPTH = 4,
  parameter int RAM_STAGE  = 2,
  parameter int TAG_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic clk,
  input  logic reset,
  opbomp_pipeline_sequencer_if.slave bus
);
  logic [PIPE_DEPTH-1:0] r_v;
  logic [TAG_WIDTH-1:0]  r_t [PIPE_DEPTH];
  logic [CNT_WIDTH-1:0]  r_frame_count;
  logic [CNT_WIDTH-1:0]  r_stall_count;

  logic                  w_stall;
  logic                  w_advance;
  logic                  w_out_fire;
  logic [PIPE_DEPTH-1:0] w_stage_en;

  assign w_stall    = r_v[PIPE_DEPTH-1] & ~bus.out_ready;
  assign w_advance  = ~w_stall & ~bus.flush;
  assign w_out_fire = r_v[PIPE_DEPTH-1] & bus.out_ready & ~bus.flush;

  // Only stages receiving a real frame are enabled, so bubbles never toggle datapath registers.
  always_comb begin
    w_stage_en = '0;
    if (w_advance && !reset) begin
      w_stage_en[0] = bus.in_valid;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        w_stage_en[i] = r_v[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v           <= '0;
      r_frame_count <= '0;
      r_stall_count <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_t[i] <= '0;
      end
    end else begin
      if (bus.flush) begin
        r_v <= '0;
      end else if (w_advance) begin
        r_v <= {r_v[PIPE_DEPTH-2:0], bus.in_valid};
        // Tags follow their frame; bubble slots keep whatever tag they last held.
        if (bus.in_valid) begin
          r_t[0] <= bus.in_tag;
        end
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          if (r_v[i-1]) begin
            r_t[i] <= r_t[i-1];
          end
        end
      end
      if (w_out_fire) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
      if (w_stall && !bus.flush && !(&r_stall_count)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign bus.in_ready    = w_advance;
  assign bus.stage_en    = w_stage_en;
  assign bus.ram_en      = w_stage_en[RAM_STAGE];
  assign bus.out_valid   = r_v[PIPE_DEPTH-1];
  assign bus.out_tag     = r_t[PIPE_DEPTH-1];
  assign bus.busy        = |r_v;
  assign bus.frame_count = r_frame_count;
  assign bus.stall_count = r_stall_count;
endmodule

// File: tb/tb_opbomp_pipeline_sequencer.sv
// Bench for opbomp_pipeline_sequencer: a frame-list model checked every cycle plus directed literal checks.
module tb_opbomp_pipeline_sequencer;
  localparam int D  = 4;
  localparam int RS = 2;
  localparam int TW = 8;
  localparam int CW = 16;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  bit   chk_en;

  opbomp_pipeline_sequencer_if #(.PIPE_DEPTH(D), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) bus ();

  opbomp_pipeline_sequencer #(
    .PIPE_DEPTH(D), .RAM_STAGE(RS), .TAG_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs just after the edge, then wait for the sampling point
  task automatic cyc(input logic iv, input logic [TW-1:0] tag, input logic ordy,
                     input logic fl, input logic rst);
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    bus.flush     = fl;
    reset         = rst;
    @(negedge clk);
  endtask

  // model: list of in-flight frames, each with the number of pipeline moves it has made
  typedef struct {
    logic [TW-1:0] tag;
    int            steps;
  } frame_t;

  frame_t        mq[$];
  logic [CW-1:0] m_fc;
  logic [CW-1:0] m_sc;
  logic          prev_hold;
  logic [TW-1:0] prev_tag;

  always @(negedge clk) begin
    logic         exp_ov;
    logic         stl;
    logic         adv;
    logic [D-1:0] exp_en;
    exp_ov = (mq.size() > 0) && (mq[0].steps == D);
    stl    = exp_ov && !bus.out_ready;
    adv    = !stl && !bus.flush;
    exp_en = '0;
    if (adv && !reset) begin
      exp_en[0] = bus.in_valid;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].steps < D) exp_en[mq[i].steps] = 1'b1;
      end
    end
    if (chk_en) begin
      chk("m_in_ready", 32'(bus.in_ready), 32'(adv));
      chk("m_out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov) chk("m_out_tag", 32'(bus.out_tag), 32'(mq[0].tag));
      chk("m_busy", 32'(bus.busy), 32'(mq.size() > 0));
      chk("m_stage_en", 32'(bus.stage_en), 32'(exp_en));
      chk("m_ram_en", 32'(bus.ram_en), 32'(exp_en[RS]));
      chk("m_frame_count", 32'(bus.frame_count), 32'(m_fc));
      chk("m_stall_count", 32'(bus.stall_count), 32'(m_sc));
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_tag", 32'(bus.out_tag), 32'(prev_tag));
      end
    end
    prev_hold = exp_ov && !bus.out_ready && !bus.flush && !reset;
    prev_tag  = exp_ov ? mq[0].tag : '0;
    if (reset) begin
      mq.delete();
      m_fc = '0;
      m_sc = '0;
    end else begin
      if (exp_ov && bus.out_ready && !bus.flush) m_fc = m_fc + 1'b1;
      if (stl && !bus.flush && m_sc != {CW{1'b1}}) m_sc = m_sc + 1'b1;
      if (bus.flush) begin
        mq.delete();
      end else if (adv) begin
        if (exp_ov) void'(mq.pop_front());
        for (int i = 0; i < mq.size(); i++) mq[i].steps++;
        if (bus.in_valid) mq.push_back('{tag: bus.in_tag, steps: 1});
      end
    end
  end

  initial begin
    logic [D-1:0] exp_en;
    n_tests   = 0;
    n_fail    = 0;
    chk_en    = 1'b0;
    prev_hold = 1'b0;
    prev_tag  = '0;
    m_fc      = '0;
    m_sc      = '0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;

    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    chk_en = 1'b1;
    cyc(0, 8'h00, 1, 0, 0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
    chk("rst_stall_count", 32'(bus.stall_count), 32'd0);
    for (int k = 0; k < 6; k++) cyc(0, 8'h00, 1, 0, 0);

    // single frame: valid exactly 4 cycles after acceptance
    for (int k = 0; k < 6; k++) begin
      cyc(k == 0, 8'h11, 1, 0, 0);
      chk("t1_busy", 32'(bus.busy), 32'((k >= 1) && (k <= 4)));
      chk("t1_out_valid", 32'(bus.out_valid), 32'(k == 4));
      if (k == 4) chk("t1_out_tag", 32'(bus.out_tag), 32'h11);
    end
    chk("t1_frame_count", 32'(bus.frame_count), 32'd1);

    // eight back-to-back frames
    for (int c = 0; c < 13; c++) begin
      cyc(c < 8, 8'(c + 1), 1, 0, 0);
      chk("t2_out_valid", 32'(bus.out_valid), 32'((c >= 4) && (c <= 11)));
      if (c >= 4 && c <= 11) chk("t2_out_tag", 32'(bus.out_tag), 32'(c - 3));
    end
    chk("t2_frame_count", 32'(bus.frame_count), 32'd9);
    chk("t2_stall_count", 32'(bus.stall_count), 32'd0);

    // full pipeline, three cycles of backpressure
    for (int c = 0; c < 4; c++) cyc(1, 8'(8'h21 + c), 1, 0, 0);
    for (int c = 4; c < 7; c++) begin
      cyc(1, 8'h25, 0, 0, 0);
      chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t3_stage_en", 32'(bus.stage_en), 32'd0);
      chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_out_tag", 32'(bus.out_tag), 32'h21);
    end
    cyc(1, 8'h25, 1, 0, 0);
    chk("t3_stall_count", 32'(bus.stall_count), 32'd3);
    chk("t3_resume_tag", 32'(bus.out_tag), 32'h21);
    chk("t3_resume_ready", 32'(bus.in_ready), 32'd1);
    for (int c = 8; c < 12; c++) begin
      cyc(0, 8'h00, 1, 0, 0);
      chk("t3_out_valid2", 32'(bus.out_valid), 32'd1);
      chk("t3_out_tag2", 32'(bus.out_tag), 32'(8'h21 + c - 7));
    end
    cyc(0, 8'h00, 1, 0, 0);
    chk("t3_drained", 32'(bus.out_valid), 32'd0);
    chk("t3_frame_count", 32'(bus.frame_count), 32'd14);

    // two frames with a bubble: diagonal enables, ram_en at n+2 and n+4
    for (int c = 0; c < 7; c++) begin
      cyc((c == 0) || (c == 2), (c == 0) ? 8'hA0 : 8'hA2, 1, 0, 0);
      exp_en = '0;
      if (c < 4) exp_en[c] = 1'b1;
      if (c >= 2 && c < 6) exp_en[c-2] = 1'b1;
      chk("t4_stage_en", 32'(bus.stage_en), 32'(exp_en));
      chk("t4_ram_en", 32'(bus.ram_en), 32'((c == 2) || (c == 4)));
      if (c == 4) chk("t4_tag_a0", 32'(bus.out_tag), 32'hA0);
      if (c == 6) chk("t4_tag_a2", 32'(bus.out_tag), 32'hA2);
    end

    // flush with three frames in flight
    for (int c = 0; c < 3; c++) cyc(1, 8'(8'h50 + c), 1, 0, 0);
    cyc(1, 8'h33, 1, 1, 0);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_stage_en", 32'(bus.stage_en), 32'd0);
    chk("t5_busy_flush", 32'(bus.busy), 32'd1);
    for (int c = 4; c < 9; c++) begin
      cyc(0, 8'h00, 1, 0, 0);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("t5_frame_count", 32'(bus.frame_count), 32'd16);

    // reset while full and stalled
    for (int c = 0; c < 4; c++) cyc(1, 8'(8'h60 + c), 1, 0, 0);
    cyc(1, 8'h70, 0, 0, 0);
    cyc(1, 8'h70, 0, 0, 0);
    cyc(1, 8'h70, 0, 0, 1);
    chk("t6_stall_before", 32'(bus.stall_count), 32'd5);
    chk("t6_fc_before", 32'(bus.frame_count), 32'd16);
    cyc(0, 8'h00, 1, 0, 0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_frame_count", 32'(bus.frame_count), 32'd0);
    chk("t6_stall_count", 32'(bus.stall_count), 32'd0);
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_out_tag", 32'(bus.out_tag), 32'h00);
    for (int c = 0; c < 3; c++) cyc(0, 8'h00, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
